// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler.
// Expands the cipher key forward to the round-10 key, then walks the schedule
// backwards one round per cycle and streams round keys 10..0 over valid/ready.
// Only the current round key is held; nothing of the 44-word expansion is stored.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   key_in    cipher key (round-10 key when LOAD_LAST=1), w0 = key_in[127:96]
//   start     begin a schedule; honoured only when idle
//   busy      high whenever the scheduler is not idle
//   rk_valid  rk_out / rk_round hold a round key
//   rk_ready  consumer accepts the key when rk_valid && rk_ready
//   rk_out    current round key, same word/byte order as key_in
//   rk_round  round index of rk_out, 10 down to 0
//   done      one-cycle pulse after round 0 has been accepted
module aes_inv_key_sched #(
  parameter int unsigned LOAD_LAST = 0,
  parameter int unsigned NR        = 10   // only 10 (AES-128) is supported
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         start,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  localparam int unsigned KEY_W = 128;
  localparam int unsigned WRD_W = 32;
  localparam int unsigned RND_W = 4;

  localparam logic [RND_W-1:0] RND_LAST = RND_W'(NR);
  localparam logic [RND_W-1:0] RND_PRE  = RND_W'(NR - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_REV  = 2'd2;

  // Forward S-box, one 16-entry row per line, entry 0 leftmost.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // SubWord: S-box applied to each byte of a word.
  function automatic logic [WRD_W-1:0] sub_word(input logic [WRD_W-1:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Round constant for round r (1..10), zero elsewhere.
  function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [KEY_W-1:0] key_q,   key_d;
  logic [RND_W-1:0] rnd_q,   rnd_d;
  logic             busy_q,  busy_d;
  logic             valid_q, valid_d;
  logic             done_q,  done_d;

  // Round datapath: one SubWord/Rcon path shared by the forward and reverse steps.
  logic [WRD_W-1:0] w0, w1, w2, w3;
  logic [WRD_W-1:0] inv_d3;
  logic [WRD_W-1:0] sub_in, sub_out, t_word;
  logic [RND_W-1:0] rc_idx;
  logic [KEY_W-1:0] fwd_key, inv_key;
  logic [WRD_W-1:0] f0, f1, f2, f3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // In reverse the previous round's last word is d^c, which feeds SubWord.
  assign inv_d3  = w3 ^ w2;
  assign sub_in  = (state_q == ST_REV) ? inv_d3 : w3;
  assign sub_out = sub_word({sub_in[23:0], sub_in[31:24]});
  // Forward round rnd produces round rnd+1; reverse undoes round rnd itself.
  assign rc_idx  = (state_q == ST_REV) ? rnd_q : RND_W'(rnd_q + 4'd1);
  assign t_word  = sub_out ^ {rcon(rc_idx), 24'h000000};

  assign f0      = w0 ^ t_word;
  assign f1      = w1 ^ f0;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {f0, f1, f2, f3};
  assign inv_key = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, inv_d3};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The cycle carrying the done pulse still belongs to the finished schedule.
        if (start && !done_q) begin
          key_d  = key_in;
          busy_d = 1'b1;
          if (LOAD_LAST != 0) begin
            state_d = ST_REV;
            rnd_d   = RND_LAST;
            valid_d = 1'b1;
          end else begin
            state_d = ST_FWD;
            rnd_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      ST_FWD: begin
        key_d = fwd_key;
        rnd_d = RND_W'(rnd_q + 4'd1);
        if (rnd_q == RND_PRE) begin
          state_d = ST_REV;
          valid_d = 1'b1;
        end
      end
      ST_REV: begin
        if (rk_ready) begin
          if (rnd_q != '0) begin
            key_d = inv_key;
            rnd_d = RND_W'(rnd_q - 4'd1);
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_out   = key_q;
  assign rk_round = rnd_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched: instance 0 runs the full forward
// phase, instance 1 is built with LOAD_LAST=1. Expected keys come from a full
// 44-word forward expansion with an S-box derived from GF(2^8) arithmetic.
module tb_aes_inv_key_sched;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk;
  logic         rst;
  logic         start_s    [2];
  logic         ready_s    [2];
  logic [127:0] key_s      [2];
  logic         busy_s     [2];
  logic         valid_s    [2];
  logic         done_s     [2];
  logic [127:0] rk_out_s   [2];
  logic [3:0]   rk_round_s [2];

  int errors;
  int checks;

  logic [7:0] sbox_m [256];
  logic [7:0] rcon_m [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] r10;
    logic [127:0] r1;
  } vec_t;

  aes_inv_key_sched #(.LOAD_LAST(0), .NR(10)) dut0 (
    .clk(clk), .rst(rst), .key_in(key_s[0]), .start(start_s[0]),
    .busy(busy_s[0]), .rk_valid(valid_s[0]), .rk_ready(ready_s[0]),
    .rk_out(rk_out_s[0]), .rk_round(rk_round_s[0]), .done(done_s[0])
  );

  aes_inv_key_sched #(.LOAD_LAST(1), .NR(10)) dut1 (
    .clk(clk), .rst(rst), .key_in(key_s[1]), .start(start_s[1]),
    .busy(busy_s[1]), .rk_valid(valid_s[1]), .rk_ready(ready_s[1]),
    .rk_out(rk_out_s[1]), .rk_round(rk_round_s[1]), .done(done_s[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_m[0] = 8'h00;
    rcon_m[1] = 8'h01;
    for (int i = 2; i < 11; i++) rcon_m[i] = gmul(rcon_m[i-1], 8'h02);
  endtask

  // Full forward expansion into 44 words; round r key = words 4r..4r+3.
  task automatic expand(input logic [127:0] k, output logic [127:0] rk [11]);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0)
        t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]}
            ^ {rcon_m[i/4], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_reset_state(input int d);
    chk("rst_busy",  128'(busy_s[d]),     128'd0);
    chk("rst_valid", 128'(valid_s[d]),    128'd0);
    chk("rst_done",  128'(done_s[d]),     128'd0);
    chk("rst_rkout", rk_out_s[d],         128'd0);
    chk("rst_round", 128'(rk_round_s[d]), 128'd0);
  endtask

  // One full schedule on instance d. k0 is the round-0 key the sequence must
  // expand from; kin is what is presented on key_in. With noise set, start is
  // held high with random key_in while busy and in the done cycle.
  task automatic run_sched(input int d, input logic [127:0] kin, input logic [127:0] k0,
                           input int stall_pct, input bit noise, output logic [127:0] got [11]);
    logic [127:0] exp [11];
    logic [127:0] hold_k;
    logic [3:0]   hold_r;
    bit           rdy, was_stall;
    int           cyc, r, guard;
    expand(k0, exp);
    for (int i = 0; i < 11; i++) got[i] = '0;
    key_s[d]   = kin;
    start_s[d] = 1'b1;
    ready_s[d] = 1'b0;
    tick();
    start_s[d] = noise;
    if (noise) key_s[d] = rand128();
    chk("busy_after_start", 128'(busy_s[d]), 128'd1);
    cyc = 0;
    while (!valid_s[d] && cyc < 40) begin
      tick();
      cyc++;
      if (noise) key_s[d] = rand128();
      chk("busy_fwd", 128'(busy_s[d]), 128'd1);
      chk("done_fwd", 128'(done_s[d]), 128'd0);
    end
    chk("first_valid_latency", 128'(cyc), (d == 0) ? 128'd10 : 128'd0);
    r = 10; was_stall = 1'b0; guard = 0; hold_k = '0; hold_r = '0;
    while (r >= 0 && guard < 300) begin
      if (was_stall) begin
        chk("stall_hold_key",   rk_out_s[d],         hold_k);
        chk("stall_hold_round", 128'(rk_round_s[d]), 128'(hold_r));
      end
      chk("rev_valid", 128'(valid_s[d]),    128'd1);
      chk("rev_done",  128'(done_s[d]),     128'd0);
      chk("rev_round", 128'(rk_round_s[d]), 128'(r));
      chk("rev_key",   rk_out_s[d],         exp[r]);
      got[r] = rk_out_s[d];
      hold_k = rk_out_s[d];
      hold_r = rk_round_s[d];
      rdy = ($urandom_range(0, 99) >= stall_pct);
      ready_s[d] = rdy;
      was_stall = !rdy;
      if (noise) key_s[d] = rand128();
      tick();
      guard++;
      if (rdy) r--;
    end
    chk("rev_walk_bounded", 128'(r < 0), 128'd1);
    ready_s[d] = 1'b0;
    if (noise) key_s[d] = rand128();
    chk("done_pulse",     128'(done_s[d]),  128'd1);
    chk("valid_drop",     128'(valid_s[d]), 128'd0);
    tick();
    start_s[d] = 1'b0;
    chk("done_one_cycle", 128'(done_s[d]),  128'd0);
    chk("idle_valid",     128'(valid_s[d]), 128'd0);
    chk("idle_busy",      128'(busy_s[d]),  128'd0);
  endtask

  initial begin
    vec_t         tbl [2];
    logic [127:0] got [11];
    logic [127:0] e   [11];
    logic [127:0] k;
    int           n;

    tbl[0] = '{key: FIPS_KEY, r10: FIPS_R10, r1: 128'ha0fafe1788542cb123a339392a6c7605};
    tbl[1] = '{key: 128'h0,   r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
               r1: 128'h62636363626363636263636362636363};

    errors = 0; checks = 0;
    clk = 1'b0; rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; ready_s[d] = 1'b0; key_s[d] = '0;
    end
    build_tables();
    tick(); tick();
    chk_reset_state(0);
    chk_reset_state(1);
    rst = 1'b0;
    tick();

    // Known vectors on both instances, no backpressure.
    for (int i = 0; i < 2; i++) begin
      run_sched(0, tbl[i].key, tbl[i].key, 0, 1'b0, got);
      chk("vec_r10", got[10], tbl[i].r10);
      chk("vec_r1",  got[1],  tbl[i].r1);
      chk("vec_r0",  got[0],  tbl[i].key);
      run_sched(1, tbl[i].r10, tbl[i].key, 0, 1'b0, got);
      chk("last_r1", got[1], tbl[i].r1);
      chk("last_r0", got[0], tbl[i].key);
    end

    // Backpressure on the FIPS key.
    run_sched(0, FIPS_KEY, FIPS_KEY, 45, 1'b0, got);
    chk("bp_r10", got[10], FIPS_R10);

    // start/key_in noise while busy and during the done pulse.
    run_sched(0, FIPS_KEY, FIPS_KEY, 20, 1'b1, got);
    run_sched(1, FIPS_R10, FIPS_KEY, 20, 1'b1, got);

    // Reset in the forward phase.
    key_s[0] = FIPS_KEY; start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("fwd_busy_before_rst", 128'(busy_s[0]), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state(0);
    run_sched(0, FIPS_KEY, FIPS_KEY, 0, 1'b0, got);

    // Reset in the reverse phase at round 5.
    key_s[0] = FIPS_KEY; start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    n = 0;
    while (!valid_s[0] && n < 40) begin tick(); n++; end
    ready_s[0] = 1'b1;
    while (rk_round_s[0] != 4'd5 && n < 80) begin tick(); n++; end
    chk("rev_round5_reached", 128'(rk_round_s[0]), 128'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0; ready_s[0] = 1'b0;
    chk_reset_state(0);
    run_sched(0, FIPS_KEY, FIPS_KEY, 0, 1'b0, got);

    // Random keys with random backpressure.
    for (int i = 0; i < 24; i++) begin
      k = rand128();
      run_sched(0, k, k, 30, 1'b0, got);
    end
    for (int i = 0; i < 8; i++) begin
      k = rand128();
      expand(k, e);
      run_sched(1, e[10], k, 30, 1'b0, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
